// File: rtl/apb_pkg.sv
// Shared types and constants for the two-requester APB arbiter.
package apb_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int NUM_REQ    = 2;
  localparam int REQ_IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;
endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin pick: search starts one past the last-granted index and wraps.
module apb_rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o
);
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IDX_W'((int'(ptr_i) + k) % N);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end
endmodule

// File: rtl/apb_arbiter.sv
// Two-requester APB master: round-robin grant, one transfer at a time,
// ACCESS-phase timeout reported as an error completion.
module apb_arbiter
  import apb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ-1:0]        i_write,
  input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_wdata,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic [NUM_REQ-1:0]        o_done,
  output logic [DATA_W-1:0]         o_rdata,
  output logic                      o_err,
  output logic [ADDR_W-1:0]         PADDR,
  output logic                      PWRITE,
  output logic [DATA_W-1:0]         PWDATA,
  output logic                      PSELx,
  output logic                      PENABLE,
  input  logic [DATA_W-1:0]         PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int IDX_W  = REQ_IDX_W;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("apb_arbiter: TIMEOUT must be in 2..255");
  end

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               write_q, write_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;

  apb_rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i   (i_req),
    .ptr_i   (ptr_q),
    .grant_o (arb_gnt)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= IDX_W'(1);
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wait_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wait_q  <= wait_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wait_d  = wait_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (|i_req) begin
          grant_d = arb_gnt;
          wait_d  = '0;
          state_d = SETUP;
          for (int n = 0; n < NUM_REQ; n++) begin
            if (arb_gnt[n]) begin
              ptr_d   = IDX_W'(n);
              write_d = i_write[n];
              addr_d  = i_addr[n*ADDR_W +: ADDR_W];
              wdata_d = i_wdata[n*DATA_W +: DATA_W];
            end
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // PREADY is checked first so a response on the last allowed cycle wins
        if (PREADY) begin
          err_d   = PSLVERR;
          rdata_d = write_q ? '0 : PRDATA;
          state_d = RESP;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      RESP: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_grant = grant_q;
  assign o_done  = (state_q == RESP) ? grant_q : '0;
  assign o_rdata = rdata_q;
  assign o_err   = err_q;
  assign PADDR   = addr_q;
  assign PWRITE  = write_q;
  assign PWDATA  = wdata_q;
  assign PSELx   = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE = (state_q == ACCESS);
endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, APB address width.
REQ-002 Parameter DATA_W, 32, APB data width.
REQ-003 Parameter TIMEOUT, 16, maximum ACCESS-phase cycles before abort; legal range 2..255.
REQ-004 i_clk  in  1  single clock; all logic rising-edge.
REQ-005 i_reset_n  in  1  asynchronous, active-low reset.
REQ-006 i_req  in  2  per-requester transfer request, bit n = requester n.
REQ-007 i_write  in  2  per-requester direction, 1 = write.
REQ-008 i_addr  in  2*ADDR_W  requester n address at [n*ADDR_W +: ADDR_W].
REQ-009 i_wdata  in  2*DATA_W  requester n write data at [n*DATA_W +: DATA_W].
REQ-010 o_grant  out  2  one-hot owner of the bus, zero when idle.
REQ-011 o_done  out  2  one-cycle completion pulse to the owning requester.
REQ-012 o_rdata  out  DATA_W  read data, valid while o_done is non-zero.
REQ-013 o_err  out  1  error flag, valid while o_done is non-zero.
REQ-014 PADDR, PWRITE, PWDATA, PSELx, PENABLE  out  ADDR_W/1/DATA_W/1/1  APB master request signals.
REQ-015 PRDATA, PREADY, PSLVERR  in  DATA_W/1/1  APB slave response signals.

Function
REQ-016 The FSM SHALL have the states IDLE, SETUP, ACCESS and RESP.
REQ-017 IDLE: if any i_req bit is high, the block SHALL grant one requester, latch its i_write/i_addr/i_wdata, and go to SETUP; otherwise it SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: with both requesting, grant goes to the requester not granted last; the last-grant pointer updates on every grant.
REQ-019 i_req SHALL be sampled only in IDLE; a request held high past o_done counts as a new request.
REQ-020 SETUP: PSELx=1, PENABLE=0; the next state SHALL be ACCESS unconditionally.
REQ-021 ACCESS: PSELx=1, PENABLE=1; PREADY=1 SHALL move the FSM to RESP with o_err<=PSLVERR and o_rdata<=PRDATA for reads or 0 for writes.
REQ-022 ACCESS with PREADY=0 SHALL increment a wait counter; after TIMEOUT ACCESS cycles without PREADY, the FSM SHALL go to RESP with o_err=1 and o_rdata=0.
REQ-023 If PREADY rises on the final allowed ACCESS cycle, the transfer SHALL complete normally (PREADY wins over timeout).
REQ-024 RESP: PSELx=0, PENABLE=0; o_done[owner]=1 for exactly this cycle; the next state SHALL be IDLE.
REQ-025 PADDR/PWRITE/PWDATA SHALL be driven from latched registers, stable from SETUP through ACCESS, and SHALL hold their last values in IDLE/RESP.
REQ-026 o_grant SHALL be non-zero from SETUP through RESP and zero in IDLE.
REQ-027 Minimum latency: request sampled in IDLE cycle N, then SETUP at N+1, ACCESS at N+2, and o_done at N+3 when PREADY=1 at N+2.
REQ-028 The wait counter SHALL be $clog2(TIMEOUT+1) bits wide and clear on entry to SETUP.

Reset
REQ-029 Asserting i_reset_n low SHALL immediately force state IDLE, clear all outputs and the wait counter to 0, and set the last-grant pointer to 1, so requester 0 wins first.
REQ-030 Reset asserted mid-transfer SHALL abort without emitting o_done; after release the block SHALL restart from IDLE.

Structure
REQ-031 Package apb_pkg SHALL hold the FSM state enum, the ADDR_W/DATA_W defaults and the requester-count constant (2).
REQ-032 Round-robin grant selection SHALL be a sub-module apb_rr_arbiter (inputs: req, pointer; output: one-hot grant).

Verification
REQ-033 Requester 0 writes addr 0x4, data 0xDEADBEEF, PREADY tied 1 -> SETUP, ACCESS, then o_done=2'b01 at cycle N+3 with o_err=0 and o_rdata=0.
REQ-034 Requester 1 reads addr 0x8, slave returns PRDATA=0x12345678 after 3 wait cycles -> o_done=2'b10, o_rdata=0x12345678, and PADDR stays 0x8 throughout.
REQ-035 Both requesters held high for 4 transfers -> grants follow the order 0,1,0,1.
REQ-036 PREADY held 0 with TIMEOUT=16 -> exactly 16 ACCESS cycles, then o_done with o_err=1 and o_rdata=0; with PREADY=1 on the 16th cycle -> normal completion with o_err=0.
REQ-037 Slave returns PSLVERR=1 with PREADY=1 -> o_err=1 on the o_done cycle.
REQ-038 Reset asserted in ACCESS -> PSELx, PENABLE and o_grant go 0 without a clock edge, no o_done is emitted, and requester 0 is granted first after release.
